// File: rtl/mem_line_bridge_if.sv
// Memory-side bridge interface: cache-controller memside port plus the word bus to memory.
// The slave modport is the bridge's view; the master modport is the surrounding
// environment (cache controller driving strobes, memory answering beats).
interface mem_line_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 32
);

  // Cache-controller side
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_write_data;
  logic [LINE_WIDTH-1:0] mem_read_data;
  logic                  mem_read_data_ready;
  logic                  mem_wait;
  logic                  proto_err;

  // Word bus to main memory
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [WORD_WIDTH-1:0] bus_wdata;
  logic [WORD_WIDTH-1:0] bus_rdata;
  logic                  bus_ack;

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data,
    output mem_read_data_ready,
    output mem_wait,
    output proto_err,
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data,
    input  mem_read_data_ready,
    input  mem_wait,
    input  proto_err,
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/mem_line_bridge.sv
// mem_line_bridge: serialises 128-bit cache line writebacks/refills into four 32-bit
// req/ack beats. One refill may be parked behind an in-flight writeback.
// Optional build macro MEM_BRIDGE_CWF_EN: refills start at the critical word
// (mem_addr[3:2]) and wrap; words are still stored at their natural position.
module mem_line_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mem_line_bridge_if.slave bif
);

  localparam int unsigned BEATS   = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned LINE_AW = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    StIdle,
    StWrBeat,
    StRdBeat,
    StRdDone
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            beat_q, beat_d;          // word index of the beat on the bus
  logic [1:0]            cnt_q, cnt_d;            // beats completed in this line
  logic [LINE_AW-1:0]    line_q, line_d;          // line address of the active transfer
  logic [LINE_WIDTH-1:0] wline_q, wline_d;        // writeback line being sent
  logic [LINE_WIDTH-1:0] rline_q, rline_d;        // refill line being assembled
  logic                  pend_q, pend_d;
  logic [LINE_AW-1:0]    pend_line_q, pend_line_d;
  logic [1:0]            pend_beat_q, pend_beat_d;
  logic                  proto_err_q, proto_err_d;

  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [WORD_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  ready_q, ready_d;
  logic                  mem_wait_q, mem_wait_d;

  logic                  ack;
  logic [1:0]            req_beat;
  logic                  unused_addr;

  // Acks only count while a beat is actually being requested
  assign ack = bus_req_q & bus_ack_in();

  function automatic logic bus_ack_in();
    return bif.bus_ack;
  endfunction

`ifdef MEM_BRIDGE_CWF_EN
  assign req_beat    = bif.mem_addr[3:2];
  assign unused_addr = ^bif.mem_addr[1:0];
`else
  assign req_beat    = 2'd0;
  assign unused_addr = ^bif.mem_addr[3:0];
`endif

  // Next-state logic: transfer sequencing, pending-refill slot and protocol checking
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    wline_d     = wline_q;
    rline_d     = rline_q;
    pend_d      = pend_q;
    pend_line_d = pend_line_q;
    pend_beat_d = pend_beat_q;
    proto_err_d = proto_err_q;

    unique case (state_q)
      StIdle: begin
        if (bif.mem_write) begin
          // A simultaneous refill is dropped; the writeback must not be lost
          state_d = StWrBeat;
          beat_d  = 2'd0;
          cnt_d   = 2'd0;
          line_d  = bif.mem_addr[ADDR_WIDTH-1:4];
          wline_d = bif.mem_write_data;
          if (bif.mem_read) begin
            proto_err_d = 1'b1;
          end
        end else if (bif.mem_read) begin
          state_d = StRdBeat;
          beat_d  = req_beat;
          cnt_d   = 2'd0;
          line_d  = bif.mem_addr[ADDR_WIDTH-1:4];
        end
      end

      StWrBeat: begin
        if (bif.mem_write) begin
          proto_err_d = 1'b1;
        end
        if (bif.mem_read) begin
          if (!pend_q) begin
            pend_d      = 1'b1;
            pend_line_d = bif.mem_addr[ADDR_WIDTH-1:4];
            pend_beat_d = req_beat;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        if (ack) begin
          beat_d = beat_q + 2'd1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Uses the post-capture slot so a refill arriving on the last ack still runs
            if (pend_d) begin
              state_d = StRdBeat;
              line_d  = pend_line_d;
              beat_d  = pend_beat_d;
              cnt_d   = 2'd0;
              pend_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end

      StRdBeat: begin
        if (bif.mem_read || bif.mem_write) begin
          proto_err_d = 1'b1;
        end
        if (ack) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == k[1:0]) begin
              rline_d[k*WORD_WIDTH +: WORD_WIDTH] = bif.bus_rdata;
            end
          end
          beat_d = beat_q + 2'd1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StRdDone;
          end
        end
      end

      StRdDone: begin
        if (bif.mem_read || bif.mem_write) begin
          proto_err_d = 1'b1;
        end
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output next values derived from the next state so every output is a flop
  always_comb begin
    bus_req_d   = (state_d == StWrBeat) || (state_d == StRdBeat);
    bus_we_d    = (state_d == StWrBeat);
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if (bus_req_d) begin
      bus_addr_d = {line_d, beat_d, 2'b00};
    end
    if (bus_we_d) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_d == k[1:0]) begin
          bus_wdata_d = wline_d[k*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
    ready_d    = (state_d == StRdDone);
    mem_wait_d = (state_d != StIdle) || pend_d;
  end

  // State and output registers; reset aborts any transfer and clears the error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      cnt_q       <= 2'd0;
      line_q      <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      pend_q      <= 1'b0;
      pend_line_q <= '0;
      pend_beat_q <= 2'd0;
      proto_err_q <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ready_q     <= 1'b0;
      mem_wait_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      wline_q     <= wline_d;
      rline_q     <= rline_d;
      pend_q      <= pend_d;
      pend_line_q <= pend_line_d;
      pend_beat_q <= pend_beat_d;
      proto_err_q <= proto_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ready_q     <= ready_d;
      mem_wait_q  <= mem_wait_d;
    end
  end

  assign bif.mem_read_data       = rline_q;
  assign bif.mem_read_data_ready = ready_q;
  assign bif.mem_wait            = mem_wait_q;
  assign bif.proto_err           = proto_err_q;
  assign bif.bus_req             = bus_req_q;
  assign bif.bus_we              = bus_we_q;
  assign bif.bus_addr            = bus_addr_q;
  assign bif.bus_wdata           = bus_wdata_q;

endmodule

// File: doc/mem_line_bridge.md
# mem_line_bridge

Memory-side bridge directly downstream of the 2-way cache controller. Accepts 128-bit line writeback and refill requests on the controller's memside port and serialises each into four 32-bit beats on a simple req/ack word bus to main memory. Holds one pending refill behind an in-flight writeback, so the controller's back-to-back writeback-then-refill sequence is never lost.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on both sides
- LINE_WIDTH, 128, cache line width; BEATS = LINE_WIDTH/WORD_WIDTH = 4
- WORD_WIDTH, 32, memory bus word width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_read  in  1  refill strobe (one cycle), line address on mem_addr
- mem_write  in  1  writeback strobe (one cycle), line address on mem_addr, data on mem_write_data
- mem_addr  in  ADDR_WIDTH  byte address; bits [3:0] ignored except in CWF mode
- mem_write_data  in  LINE_WIDTH  writeback line, word k at [32k+31:32k]
- mem_read_data  out  LINE_WIDTH  assembled refill line
- mem_read_data_ready  out  1  one-cycle pulse, refill line valid
- mem_wait  out  1  bridge busy or refill pending
- proto_err  out  1  sticky protocol-violation flag
- bus_req  out  1  beat request
- bus_we  out  1  1 = write beat
- bus_addr  out  ADDR_WIDTH  word-aligned beat address
- bus_wdata  out  WORD_WIDTH  write beat data
- bus_rdata  in  WORD_WIDTH  read beat data, valid when bus_ack
- bus_ack  in  1  beat completes at an edge with bus_req & bus_ack

## Operation
- States: IDLE, WR_BEAT, RD_BEAT, RD_DONE. 2-bit beat counter, 2-bit beat count, one-entry pending-read slot (flag + address).
- IDLE, mem_write only: latch line address and data; go to WR_BEAT, beat 0.
- IDLE, mem_read only: latch address; go to RD_BEAT.
- IDLE, both strobes: write accepted, read discarded, proto_err set.
- WR_BEAT: beat k presents bus_we=1, bus_addr={addr[31:4],k,2'b00}, bus_wdata=word k. On ack: k+1; after beat 3 acks, go to RD_BEAT if pending valid (pending consumed), else IDLE.
- mem_read during WR_BEAT with slot empty: captured into pending slot. Any other strobe while not IDLE (read with slot full, any write, read during RD_BEAT/RD_DONE): ignored, proto_err set.
- RD_BEAT: bus_we=0; on ack store bus_rdata in word k of the line register; after 4 beats go to RD_DONE.
- RD_DONE: mem_read_data_ready=1 for exactly one cycle; next state IDLE. mem_read_data holds stable until the next refill's first beat is written.
- Beat counter wraps 3 -> 0 modulo 4.
- mem_wait = (state != IDLE) | pending valid.

## Timing
- Registered outputs; reset values: mem_read_data 0, mem_read_data_ready 0, mem_wait 0, proto_err 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0; state IDLE, pending cleared.
- Strobe sampled at edge t in IDLE -> mem_wait=1 and bus_req=1 in cycle t+1.
- bus_req stays high across beats; addr/we/wdata stable until acked; next beat presented the cycle after the ack edge.
- bus_ack constantly 1: refill strobe cycle 0 -> beats cycles 1-4 -> mem_read_data_ready cycle 5 -> mem_wait=0 cycle 6. Writeback: beats 1-4, mem_wait=0 cycle 5.
- Writeback strobe at t, refill strobe at t+1, ack constant: write beats t+1..t+4, read beats t+5..t+8, ready at t+9; mem_wait high continuously t+1..t+9.
- bus_ack while bus_req=0 ignored.
- rst mid-operation: abort at that edge, all outputs to reset values next cycle, pending and proto_err cleared; no ready pulse.

## Configuration
- MEM_BRIDGE_CWF_EN defined: refill beats critical-word-first, starting at k=mem_addr[3:2], wrapping 3 -> 0; each word still stored at its natural position k. Writebacks unaffected.
- Undefined: refill beats always 0,1,2,3; mem_addr[3:2] ignored.

## Test plan
- Refill 0x0000_1234, ack constant, bus_rdata = 0xA0+k -> bus_addr 0x1230,0x1234,0x1238,0x123C; mem_read_data=0x000000A3_000000A2_000000A1_000000A0, ready in cycle 5.
- Writeback 0x0000_2000 with line 0x44..._33..._22..._11..., ack constant -> four write beats 0x2000..0x200C carrying 0x11..,0x22..,0x33..,0x44..; mem_wait low in cycle 5; no ready pulse.
- Writeback at t, refill 0x3000 at t+1, ack every other cycle -> all write beats complete before first read beat; mem_wait never drops before ready pulse; proto_err 0.
- Simultaneous mem_read+mem_write in IDLE; then second mem_read during RD_BEAT -> write executes only, proto_err=1 and stays 1.
- CWF build, refill 0x0000_1238 -> beat addresses 0x1238,0x123C,0x1230,0x1234; line assembled in natural order.
- rst asserted during beat 2 of a refill -> next cycle bus_req=0, mem_wait=0, no ready pulse; subsequent refill completes normally.
